// File: rtl/trx_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : trx_sched_if
//  Purpose  : Host/packet-path handshake bundle for the RX/TX turnaround
//             scheduler.
//  Revision : 1.0  initial release
// ============================================================================
interface trx_sched_if;
    logic rx_req;
    logic tx_req;
    logic pkt_rec;
    logic tx_done;
    logic rx_mode;
    logic rx_en;
    logic tx_en;
    logic busy;
    logic rx_ack;
    logic tx_ack;
    logic timeout;

    modport master (
        output rx_req, tx_req, pkt_rec, tx_done,
        input  rx_mode, rx_en, tx_en, busy, rx_ack, tx_ack, timeout
    );

    modport slave (
        input  rx_req, tx_req, pkt_rec, tx_done,
        output rx_mode, rx_en, tx_en, busy, rx_ack, tx_ack, timeout
    );
endinterface
`default_nettype wire

// File: rtl/trx_sched.sv
`default_nettype none
// ============================================================================
//  Module   : trx_sched
//  Purpose  : Half-duplex RX/TX window scheduler with round-robin grant and
//             turnaround guard. Optional RX watchdog via TRX_SCHED_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module trx_sched #(
    parameter int unsigned GUARD_CYC  = 4,
    parameter int unsigned RX_TIMEOUT = 1023
) (
    input  wire logic   clk,
    input  wire logic   rst,
    trx_sched_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RX_GUARD  = 3'd1,
        RX_ACTIVE = 3'd2,
        TX_GUARD  = 3'd3,
        TX_ACTIVE = 3'd4
    } state_t;

    localparam logic       c_GUARD_EN   = (GUARD_CYC != 0);
    localparam logic [3:0] c_GUARD_LAST = 4'(GUARD_CYC - 1);

    if (GUARD_CYC > 15) begin : g_bad_guard
        $error("GUARD_CYC must be 0..15");
    end
    if ((RX_TIMEOUT < 1) || (RX_TIMEOUT > 1023)) begin : g_bad_timeout
        $error("RX_TIMEOUT must be 1..1023");
    end

    state_t     state_q;
    logic       rx_mode_q;
    logic       rx_en_q;
    logic       tx_en_q;
    logic       busy_q;
    logic       rx_ack_q;
    logic       tx_ack_q;
    logic       last_rx_q;
    logic       armed_q;
    logic       pkt_prev_q;
    logic [3:0] guard_cnt_q;
`ifdef TRX_SCHED_TIMEOUT_EN
    localparam logic [9:0] c_TO_LAST = 10'(RX_TIMEOUT - 1);
    logic       timeout_q;
    logic [9:0] to_cnt_q;
`endif

    logic w_req_any;
    logic w_pick_rx;
    logic w_need_guard;
    logic w_pkt_rise;

    // Round-robin: RX wins a tie unless it was the last side granted.
    assign w_req_any    = bus.rx_req | bus.tx_req;
    assign w_pick_rx    = bus.rx_req & (~bus.tx_req | ~last_rx_q);
    assign w_need_guard = c_GUARD_EN & (w_pick_rx != rx_mode_q);
    assign w_pkt_rise   = bus.pkt_rec & ~pkt_prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rx_mode_q   <= 1'b1;
            rx_en_q     <= 1'b0;
            tx_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            rx_ack_q    <= 1'b0;
            tx_ack_q    <= 1'b0;
            last_rx_q   <= 1'b0;
            armed_q     <= 1'b0;
            pkt_prev_q  <= 1'b0;
            guard_cnt_q <= 4'd0;
`ifdef TRX_SCHED_TIMEOUT_EN
            timeout_q   <= 1'b0;
            to_cnt_q    <= 10'd0;
`endif
        end else begin
            // armed_q holds off grants on the first edge after reset release.
            armed_q  <= 1'b1;
            rx_ack_q <= 1'b0;
            tx_ack_q <= 1'b0;
`ifdef TRX_SCHED_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (armed_q && w_req_any) begin
                        busy_q      <= 1'b1;
                        rx_mode_q   <= w_pick_rx;
                        last_rx_q   <= w_pick_rx;
                        guard_cnt_q <= 4'd0;
                        pkt_prev_q  <= 1'b0;
`ifdef TRX_SCHED_TIMEOUT_EN
                        to_cnt_q    <= 10'd0;
`endif
                        if (w_pick_rx) begin
                            if (w_need_guard) begin
                                state_q <= RX_GUARD;
                            end else begin
                                state_q <= RX_ACTIVE;
                                rx_en_q <= 1'b1;
                            end
                        end else begin
                            if (w_need_guard) begin
                                state_q <= TX_GUARD;
                            end else begin
                                state_q <= TX_ACTIVE;
                                tx_en_q <= 1'b1;
                            end
                        end
                    end
                end

                RX_GUARD: begin
                    if (!bus.rx_req) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (guard_cnt_q == c_GUARD_LAST) begin
                        state_q    <= RX_ACTIVE;
                        rx_en_q    <= 1'b1;
                        pkt_prev_q <= 1'b0;
`ifdef TRX_SCHED_TIMEOUT_EN
                        to_cnt_q   <= 10'd0;
`endif
                    end else begin
                        guard_cnt_q <= guard_cnt_q + 4'd1;
                    end
                end

                RX_ACTIVE: begin
                    pkt_prev_q <= bus.pkt_rec;
`ifdef TRX_SCHED_TIMEOUT_EN
                    to_cnt_q   <= to_cnt_q + 10'd1;
`endif
                    // A completed packet outranks both request drop and timeout.
                    if (w_pkt_rise) begin
                        state_q  <= IDLE;
                        rx_en_q  <= 1'b0;
                        busy_q   <= 1'b0;
                        rx_ack_q <= 1'b1;
                    end else if (!bus.rx_req) begin
                        state_q <= IDLE;
                        rx_en_q <= 1'b0;
                        busy_q  <= 1'b0;
`ifdef TRX_SCHED_TIMEOUT_EN
                    end else if (to_cnt_q == c_TO_LAST) begin
                        state_q   <= IDLE;
                        rx_en_q   <= 1'b0;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
`endif
                    end
                end

                TX_GUARD: begin
                    if (!bus.tx_req) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (guard_cnt_q == c_GUARD_LAST) begin
                        state_q <= TX_ACTIVE;
                        tx_en_q <= 1'b1;
                    end else begin
                        guard_cnt_q <= guard_cnt_q + 4'd1;
                    end
                end

                TX_ACTIVE: begin
                    if (bus.tx_done) begin
                        state_q  <= IDLE;
                        tx_en_q  <= 1'b0;
                        busy_q   <= 1'b0;
                        tx_ack_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    rx_en_q <= 1'b0;
                    tx_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_mode = rx_mode_q;
    assign bus.rx_en   = rx_en_q;
    assign bus.tx_en   = tx_en_q;
    assign bus.busy    = busy_q;
    assign bus.rx_ack  = rx_ack_q;
    assign bus.tx_ack  = tx_ack_q;
`ifdef TRX_SCHED_TIMEOUT_EN
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_trx_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trx_sched
//  Purpose  : Directed vector bench for trx_sched (GUARD_CYC=4, RX_TIMEOUT=16).
//  Revision : 1.0  initial release
// ============================================================================
module tb_trx_sched;

    logic clk;
    logic rst;
    trx_sched_if bus();

    trx_sched #(
        .GUARD_CYC  (4),
        .RX_TIMEOUT (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs {rx_req, tx_req, pkt_rec, tx_done};
    // outputs {rx_mode, rx_en, tx_en, busy, rx_ack, tx_ack, timeout}.
    typedef struct {
        logic [3:0] in;
        logic [6:0] exp;
    } vec_t;

    vec_t vq[$];
    int   n_pass;
    int   n_total;

    logic [6:0] w_out;
    assign w_out = {bus.rx_mode, bus.rx_en, bus.tx_en, bus.busy,
                    bus.rx_ack, bus.tx_ack, bus.timeout};

    task automatic add(input logic [3:0] in, input logic [6:0] exp, input int n);
        vec_t v;
        v.in  = in;
        v.exp = exp;
        for (int i = 0; i < n; i++) vq.push_back(v);
    endtask

    task automatic drive(input logic [3:0] in);
        bus.rx_req  = in[3];
        bus.tx_req  = in[2];
        bus.pkt_rec = in[1];
        bus.tx_done = in[0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input logic [6:0] exp, input string tag);
        n_total++;
        if (w_out !== exp)
            $display("FAIL %s: got %b expected %b", tag, w_out, exp);
        else
            n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b0;
        drive(4'b0000);

        // RX alone from reset: no guard, then packet ack after 10 active cycles.
        add(4'b0000, 7'b1000000, 1);
        add(4'b1000, 7'b1101000, 10);
        add(4'b1010, 7'b1000100, 1);
        add(4'b0010, 7'b1000000, 1);
        add(4'b0000, 7'b1000000, 1);
        // TX with direction change: 4 guard cycles, tx_req drop ignored when active.
        add(4'b0100, 7'b0001000, 4);
        add(4'b0100, 7'b0011000, 2);
        add(4'b0000, 7'b0011000, 1);
        add(4'b0001, 7'b0000010, 1);
        add(4'b0000, 7'b0000000, 1);
        // Both requests held: RX, TX, RX alternate.
        add(4'b1100, 7'b1001000, 4);
        add(4'b1100, 7'b1101000, 1);
        add(4'b1110, 7'b1000100, 1);
        add(4'b1110, 7'b0001000, 1);
        add(4'b1100, 7'b0001000, 3);
        add(4'b1100, 7'b0011000, 1);
        add(4'b1101, 7'b0000010, 1);
        add(4'b1100, 7'b1001000, 4);
        add(4'b1100, 7'b1101000, 1);
        add(4'b1110, 7'b1000100, 1);
        add(4'b0000, 7'b1000000, 1);
        // Guard abort on cycle 2, then stray tx_done in IDLE.
        add(4'b0100, 7'b0001000, 2);
        add(4'b0000, 7'b0000000, 1);
        add(4'b0001, 7'b0000000, 2);
        add(4'b0000, 7'b0000000, 1);
        // Same-direction TX goes straight to active; RX request drop exits silently.
        add(4'b0100, 7'b0011000, 2);
        add(4'b0001, 7'b0000010, 1);
        add(4'b1000, 7'b1001000, 4);
        add(4'b1000, 7'b1101000, 1);
        add(4'b0000, 7'b1000000, 2);

        tick();
        chk(7'b1000000, "reset_state");
        #2 rst = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].in);
            tick();
            chk(vq[i].exp, $sformatf("vec%0d", i));
        end

        // Asynchronous reset in the middle of TX_GUARD.
        drive(4'b0100);
        tick(); chk(7'b0001000, "pre_rst_guard1");
        tick(); chk(7'b0001000, "pre_rst_guard2");
        #2 rst = 1'b0;
        #1 chk(7'b1000000, "async_reset");
        tick(); chk(7'b1000000, "held_reset");
        #2 rst = 1'b1;
        tick(); chk(7'b1000000, "post_rst_arm");
        for (int i = 0; i < 4; i++) begin
            tick(); chk(7'b0001000, $sformatf("post_rst_guard%0d", i));
        end
        tick(); chk(7'b0011000, "post_rst_active");
        drive(4'b0001);
        tick(); chk(7'b0000010, "post_rst_txack");
        drive(4'b0000);
        tick(); chk(7'b0000000, "post_rst_idle");

        // Long RX window with no packet.
        drive(4'b1000);
        for (int i = 0; i < 4; i++) begin
            tick(); chk(7'b1001000, $sformatf("to_guard%0d", i));
        end
        tick(); chk(7'b1101000, "to_active");
`ifdef TRX_SCHED_TIMEOUT_EN
        for (int i = 1; i < 16; i++) begin
            tick(); chk(7'b1101000, $sformatf("to_wait%0d", i));
        end
        tick(); chk(7'b1000001, "timeout_pulse");
        drive(4'b0000);
        tick(); chk(7'b1000000, "timeout_idle");
        drive(4'b1000);
        tick(); chk(7'b1101000, "to2_active");
        for (int i = 1; i < 16; i++) begin
            tick(); chk(7'b1101000, $sformatf("to2_wait%0d", i));
        end
        drive(4'b1010);
        tick(); chk(7'b1000100, "pkt_beats_timeout");
        drive(4'b0000);
        tick(); chk(7'b1000000, "to2_idle");
`else
        for (int i = 1; i < 21; i++) begin
            tick(); chk(7'b1101000, $sformatf("no_to_wait%0d", i));
        end
        drive(4'b0000);
        tick(); chk(7'b1000000, "no_to_idle");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
